// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: opcodes, FSM state encoding and address step for the debug UART.
package debug_uart_pkg;

    localparam logic [7:0] OP_SET_ADDR = 8'h10;
    localparam logic [7:0] OP_SET_DATA = 8'h20;
    localparam logic [7:0] OP_WR_WORD  = 8'h30;
    localparam logic [7:0] OP_WR_HI    = 8'h31;
    localparam logic [7:0] OP_WR_LO    = 8'h32;
    localparam logic [7:0] OP_RD_WORD  = 8'h40;
    localparam logic [7:0] OP_RD_LO    = 8'h41;
    localparam logic [7:0] OP_STATUS   = 8'h50;
    localparam logic [7:0] OP_ATTACH   = 8'h60;
    localparam logic [7:0] OP_DETACH   = 8'h61;

    localparam logic [15:0] ADDR_INC = 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        ARG_HI,
        ARG_LO,
        WRITE,
        READ1,
        READ2,
        SEND
    } state_t;

endpackage

// File: rtl/debug_uart_if.sv
// debug_uart_if: UART byte strobes plus the debug memory-bus signals.
// master = the debug UART controller, slave = the UART/memory side.
interface debug_uart_if;
    logic        dix;
    logic [7:0]  id;
    logic        dox;
    logic [7:0]  od;
    logic        csu;
    logic [15:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] din;
    logic [15:0] dout;
    logic [7:0]  status;

    modport master (
        input  dix, id, din, status,
        output dox, od, csu, addr, r, w, dout
    );

    modport slave (
        output dix, id, din, status,
        input  dox, od, csu, addr, r, w, dout
    );
endinterface

// File: rtl/debug_uart.sv
// debug_uart: byte-oriented debug protocol that drives the memory bus.
// Optional macro DBG_AUTOINC_EN: addr advances by 2 after each write and each 0x41.
module debug_uart
    import debug_uart_pkg::*;
(
    input logic          clk,
    input logic          nreset,
    debug_uart_if.master bus
);

    state_t      state;
    state_t      state_next;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] latch;
    logic [7:0]  od;
    logic [7:0]  arg_hi;
    logic        arg_sel;
    logic [1:0]  wsel;
    logic        attach;
    logic        dox;
    logic        csu;
    logic        r;
    logic [1:0]  w;

    assign bus.dox  = dox;
    assign bus.od   = od;
    assign bus.csu  = csu;
    assign bus.addr = addr;
    assign bus.r    = r;
    assign bus.w    = w;
    assign bus.dout = dout;

    // State register; reset aborts any argument, bus phase or pending send.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decode; bytes arriving in bus or send states are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.dix) begin
                    case (bus.id)
                        OP_SET_ADDR, OP_SET_DATA:        state_next = ARG_HI;
                        OP_WR_WORD, OP_WR_HI, OP_WR_LO:  state_next = WRITE;
                        OP_RD_WORD:                      state_next = READ1;
                        OP_RD_LO, OP_STATUS:             state_next = SEND;
                        default:                         state_next = IDLE;
                    endcase
                end
            end
            ARG_HI:  if (bus.dix) state_next = ARG_LO;
            ARG_LO:  if (bus.dix) state_next = IDLE;
            WRITE:   state_next = IDLE;
            READ1:   state_next = READ2;
            READ2:   state_next = SEND;
            SEND:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are pure functions of state so r and w can never overlap.
    always_comb begin
        dox = (state == SEND);
        r   = (state == READ1) || (state == READ2);
        w   = (state == WRITE) ? wsel : 2'b00;
        csu = attach || r || (state == WRITE);
    end

    // Datapath registers: address/data loading, read latch, response byte, attach flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr    <= '0;
            dout    <= '0;
            latch   <= '0;
            od      <= '0;
            arg_hi  <= '0;
            arg_sel <= 1'b0;
            wsel    <= 2'b00;
            attach  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dix) begin
                        case (bus.id)
                            OP_SET_ADDR: arg_sel <= 1'b0;
                            OP_SET_DATA: arg_sel <= 1'b1;
                            OP_WR_WORD:  wsel    <= 2'b11;
                            OP_WR_HI:    wsel    <= 2'b10;
                            OP_WR_LO:    wsel    <= 2'b01;
                            OP_RD_LO: begin
                                od <= latch[7:0];
`ifdef DBG_AUTOINC_EN
                                addr <= addr + ADDR_INC;
`else
                                addr <= addr;
`endif
                            end
                            OP_STATUS:   od      <= bus.status;
                            OP_ATTACH:   attach  <= 1'b1;
                            OP_DETACH:   attach  <= 1'b0;
                            default:     attach  <= attach;
                        endcase
                    end
                end
                ARG_HI: begin
                    if (bus.dix) arg_hi <= bus.id;
                end
                ARG_LO: begin
                    if (bus.dix) begin
                        if (arg_sel) dout <= {arg_hi, bus.id};
                        else         addr <= {arg_hi, bus.id};
                    end
                end
                WRITE: begin
`ifdef DBG_AUTOINC_EN
                    addr <= addr + ADDR_INC;
`else
                    addr <= addr;
`endif
                end
                READ2: begin
                    latch <= bus.din;
                    od    <= bus.din[15:8];
                end
                default: begin
                    od <= od;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart.sv
// tb_debug_uart: scoreboard bench for debug_uart; expectations are queued as
// commands are issued and a negedge monitor checks every response byte and bus cycle.
// Honours DBG_AUTOINC_EN to model the address auto-increment.
module tb_debug_uart;

    typedef struct {
        logic        r;
        logic [1:0]  w;
        logic [15:0] addr;
        logic [15:0] dout;
    } bus_ev_t;

    logic        clk;
    logic        nreset;
    int          total;
    int          bad;
    logic [7:0]  tx_q[$];
    bus_ev_t     bus_q[$];
    logic [15:0] m_addr;
    logic [15:0] m_dout;

    debug_uart_if bif();

    debug_uart dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One received byte: strobe for a cycle, then idle for gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        bif.dix = 1'b1;
        bif.id  = b;
        @(posedge clk);
        #1;
        bif.dix = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expectTx(input logic [7:0] b);
        tx_q.push_back(b);
    endtask

    task automatic expectBus(input logic rd, input logic [1:0] we);
        bus_ev_t e;
        e.r    = rd;
        e.w    = we;
        e.addr = m_addr;
        e.dout = m_dout;
        bus_q.push_back(e);
    endtask

    task automatic bumpAddr();
`ifdef DBG_AUTOINC_EN
        m_addr = m_addr + 16'd2;
`endif
    endtask

    // Monitor: pops an expectation for every dox and every active bus cycle.
    task automatic monitor();
        logic [7:0] eb;
        bus_ev_t    e;
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (bif.dox) begin
                    if (tx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL tx_unexpected got=%h expected=none", bif.od);
                    end else begin
                        eb = tx_q.pop_front();
                        checkOutput("tx_byte", {8'h00, bif.od}, {8'h00, eb});
                    end
                end
                if (bif.r || bif.w != 2'b00) begin
                    if (bus_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL bus_unexpected got r=%b w=%b addr=%h expected=none",
                                 bif.r, bif.w, bif.addr);
                    end else begin
                        e = bus_q.pop_front();
                        checkOutput("bus_r", {15'd0, bif.r}, {15'd0, e.r});
                        checkOutput("bus_w", {14'd0, bif.w}, {14'd0, e.w});
                        checkOutput("bus_addr", bif.addr, e.addr);
                        checkOutput("bus_csu", {15'd0, bif.csu}, 16'd1);
                        if (e.w != 2'b00) checkOutput("bus_dout", bif.dout, e.dout);
                    end
                end
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        m_addr     = 16'h0000;
        m_dout     = 16'h0000;
        nreset     = 1'b0;
        bif.dix    = 1'b0;
        bif.id     = 8'h00;
        bif.din    = 16'h0000;
        bif.status = 8'h00;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_addr", bif.addr, 16'h0000);
        checkOutput("rst_dox", {15'd0, bif.dox}, 16'd0);
        checkOutput("rst_csu", {15'd0, bif.csu}, 16'd0);
        @(negedge clk);
        nreset = 1'b1;

        // Address load then status readback.
        applyStimulus(8'h10, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'h34, 2);
        m_addr = 16'h1234;
        checkOutput("addr_load", bif.addr, m_addr);
        bif.status = 8'hA5;
        expectTx(8'hA5);
        applyStimulus(8'h50, 4);

        // Data load then full-word write.
        applyStimulus(8'h20, 1);
        applyStimulus(8'hBE, 1);
        applyStimulus(8'hEF, 2);
        m_dout = 16'hBEEF;
        checkOutput("dout_load", bif.dout, m_dout);
        expectBus(1'b0, 2'b11);
        applyStimulus(8'h30, 4);
        bumpAddr();
        checkOutput("addr_after_wr", bif.addr, m_addr);

        // Word read then low-byte fetch.
        bif.din = 16'h5A3C;
        expectBus(1'b1, 2'b00);
        expectBus(1'b1, 2'b00);
        expectTx(8'h5A);
        applyStimulus(8'h40, 5);
        expectTx(8'h3C);
        applyStimulus(8'h41, 4);
        bumpAddr();
        checkOutput("addr_after_rd", bif.addr, m_addr);

        // Byte-lane writes.
        expectBus(1'b0, 2'b10);
        applyStimulus(8'h31, 4);
        bumpAddr();
        expectBus(1'b0, 2'b01);
        applyStimulus(8'h32, 4);
        bumpAddr();
        checkOutput("addr_after_bytes", bif.addr, m_addr);

        // Address wrap at the top of the space.
        applyStimulus(8'h10, 1);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'hFE, 2);
        m_addr = 16'hFFFE;
        expectBus(1'b0, 2'b01);
        applyStimulus(8'h32, 4);
        bumpAddr();
        checkOutput("addr_wrap", bif.addr, m_addr);

        // Attach holds csu, detach releases, unknown opcode is silent.
        applyStimulus(8'h60, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("csu_attached", {15'd0, bif.csu}, 16'd1);
        end
        applyStimulus(8'h61, 2);
        checkOutput("csu_detached", {15'd0, bif.csu}, 16'd0);
        applyStimulus(8'h7F, 4);
        checkOutput("csu_after_7f", {15'd0, bif.csu}, 16'd0);

        // A byte arriving during a read bus phase is dropped.
        bif.din    = 16'h1357;
        bif.status = 8'hEE;
        expectBus(1'b1, 2'b00);
        expectBus(1'b1, 2'b00);
        expectTx(8'h13);
        applyStimulus(8'h40, 0);
        applyStimulus(8'h50, 4);
        expectTx(8'h57);
        applyStimulus(8'h41, 4);
        bumpAddr();

        // Reset in the middle of an address argument.
        applyStimulus(8'h10, 1);
        applyStimulus(8'h12, 0);
        nreset = 1'b0;
        #1;
        checkOutput("mid_rst_addr", bif.addr, 16'h0000);
        checkOutput("mid_rst_dout", bif.dout, 16'h0000);
        checkOutput("mid_rst_od", {8'h00, bif.od}, 16'h0000);
        checkOutput("mid_rst_dox", {15'd0, bif.dox}, 16'd0);
        checkOutput("mid_rst_csu", {15'd0, bif.csu}, 16'd0);
        checkOutput("mid_rst_r", {15'd0, bif.r}, 16'd0);
        checkOutput("mid_rst_w", {14'd0, bif.w}, 16'd0);
        @(negedge clk);
        nreset = 1'b1;
        m_addr = 16'h0000;
        m_dout = 16'h0000;
        bif.status = 8'h3C;
        expectTx(8'h3C);
        applyStimulus(8'h50, 4);
        expectTx(8'h00);
        applyStimulus(8'h41, 4);
        bumpAddr();
        checkOutput("addr_post_rst", bif.addr, m_addr);

        // Let outstanding expectations drain within a bounded window.
        for (int i = 0; i < 50 && (tx_q.size() != 0 || bus_q.size() != 0); i++) @(posedge clk);
        #1;
        checkOutput("tx_drained", 16'(tx_q.size()), 16'd0);
        checkOutput("bus_drained", 16'(bus_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
